mc_ctrl: RTL and testbench

- Multi-cycle control FSM for the single-issue MIPS subset datapath.
- Sequences the PC, IR, register file, ALU, immediate extender (EOp) and data/instruction memory across FETCH/DECODE/EXEC/MEM/WB.
- Talks to a shared memory through a req/ready handshake.
- Sits between the IR and every datapath write-enable and mux select.

---
 rtl/mc_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS subset datapath (FETCH/DECODE/EXEC/MEM/WB).
// Optional retired-instruction counter enabled by defining MC_INSTR_CNT_EN.
module mc_ctrl #(
    parameter int RESET_STATE_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              instr,
    input  logic                     zero,
    input  logic                     mem_ready,
    output logic                     mem_req,
    output logic                     mem_sel,
    output logic                     PCWr,
    output logic                     IRWr,
    output logic                     RegWr,
    output logic                     MemWr,
    output logic [1:0]               NPCSel,
    output logic [1:0]               EOp,
    output logic [1:0]               ALUOp,
    output logic                     ALUSrc,
    output logic [1:0]               RegDst,
    output logic [1:0]               WDSel,
`ifdef MC_INSTR_CNT_EN
    output logic [31:0]              instr_cnt,
`endif
    output logic [RESET_STATE_W-1:0] state_o
);

    typedef enum logic [RESET_STATE_W-1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB_ALU,
        S_WB_MEM
    } state_t;

    state_t state_q, state_d;

    logic [5:0] op;
    logic [5:0] funct;
    logic       is_r;
    logic       is_addu, is_subu, is_jr;
    logic       is_ori, is_lw, is_sw, is_beq;
    logic       is_lui, is_j, is_jal;
    logic       to_exec;
    logic       unused_instr;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign unused_instr = ^instr[25:6];

    assign is_r    = (op == 6'b000000);
    assign is_addu = is_r && (funct == 6'b100001);
    assign is_subu = is_r && (funct == 6'b100011);
    assign is_jr   = is_r && (funct == 6'b001000);
    assign is_ori  = (op == 6'b001101);
    assign is_lw   = (op == 6'b100011);
    assign is_sw   = (op == 6'b101011);
    assign is_beq  = (op == 6'b000100);
    assign is_lui  = (op == 6'b001111);
    assign is_j    = (op == 6'b000010);
    assign is_jal  = (op == 6'b000011);

    // Instructions that need an ALU cycle after decode.
    assign to_exec = is_addu | is_subu | is_ori | is_lui
                   | is_lw | is_sw | is_beq;

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        mem_sel = 1'b0;
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        RegWr   = 1'b0;
        MemWr   = 1'b0;
        NPCSel  = 2'd0;
        EOp     = 2'd0;
        ALUOp   = 2'd0;
        ALUSrc  = 1'b0;
        RegDst  = 2'd0;
        WDSel   = 2'd0;

        unique case (1'b1)
            is_ori:  EOp = 2'd1;
            is_lui:  EOp = 2'd2;
            is_beq:  EOp = 2'd3;
            default: EOp = 2'd0;
        endcase

        unique case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWr    = 1'b1;
                    PCWr    = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_j || is_jal) begin
                    PCWr    = 1'b1;
                    NPCSel  = 2'd2;
                    state_d = S_FETCH;
                    if (is_jal) begin
                        RegWr  = 1'b1;
                        RegDst = 2'd2;
                        WDSel  = 2'd2;
                    end
                end else if (is_jr) begin
                    PCWr    = 1'b1;
                    NPCSel  = 2'd3;
                    state_d = S_FETCH;
                end else if (to_exec) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (is_addu || is_subu) begin
                    ALUOp   = is_subu ? 2'd1 : 2'd0;
                    state_d = S_WB_ALU;
                end else if (is_ori || is_lui) begin
                    ALUOp   = 2'd2;
                    ALUSrc  = 1'b1;
                    state_d = S_WB_ALU;
                end else if (is_lw || is_sw) begin
                    ALUSrc  = 1'b1;
                    state_d = S_MEM;
                end else if (is_beq) begin
                    ALUOp  = 2'd1;
                    PCWr   = zero;
                    NPCSel = 2'd1;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                ALUSrc  = 1'b1;
                if (is_sw) begin
                    MemWr = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end else if (is_lw) begin
                    if (mem_ready) state_d = S_WB_MEM;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB_ALU: begin
                RegWr   = 1'b1;
                RegDst  = is_r ? 2'd1 : 2'd0;
                state_d = S_FETCH;
            end
            S_WB_MEM: begin
                RegWr   = 1'b1;
                WDSel   = 2'd1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset silences every enable and select in the same cycle.
        if (reset) begin
            state_d = S_FETCH;
            mem_req = 1'b0;
            mem_sel = 1'b0;
            PCWr    = 1'b0;
            IRWr    = 1'b0;
            RegWr   = 1'b0;
            MemWr   = 1'b0;
            NPCSel  = 2'd0;
            EOp     = 2'd0;
            ALUOp   = 2'd0;
            ALUSrc  = 1'b0;
            RegDst  = 2'd0;
            WDSel   = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

`ifdef MC_INSTR_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != S_FETCH && state_d == S_FETCH) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign instr_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed steps plus randomized instruction
// streams compared against a per-instruction transaction model.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_sel, PCWr, IRWr, RegWr, MemWr;
    logic [1:0]  NPCSel, EOp, ALUOp, RegDst, WDSel;
    logic        ALUSrc;
    logic [2:0]  state_o;
`ifdef MC_INSTR_CNT_EN
    logic [31:0] instr_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_sel   (mem_sel),
        .PCWr      (PCWr),
        .IRWr      (IRWr),
        .RegWr     (RegWr),
        .MemWr     (MemWr),
        .NPCSel    (NPCSel),
        .EOp       (EOp),
        .ALUOp     (ALUOp),
        .ALUSrc    (ALUSrc),
        .RegDst    (RegDst),
        .WDSel     (WDSel),
`ifdef MC_INSTR_CNT_EN
        .instr_cnt (instr_cnt),
`endif
        .state_o   (state_o)
    );

    // Instruction classes used by the model.
    localparam int C_ADDU = 0, C_SUBU = 1, C_JR  = 2, C_ORI = 3;
    localparam int C_LW   = 4, C_SW   = 5, C_BEQ = 6, C_LUI = 7;
    localparam int C_J    = 8, C_JAL  = 9, C_NOP = 10;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int c);
        logic [31:0] r;
        r = $urandom;
        case (c)
            C_ADDU:  return {6'h00, r[25:6], 6'h21};
            C_SUBU:  return {6'h00, r[25:6], 6'h23};
            C_JR:    return {6'h00, 5'd31, 15'h0, 6'h08};
            C_ORI:   return {6'h0d, r[25:0]};
            C_LW:    return {6'h23, r[25:0]};
            C_SW:    return {6'h2b, r[25:0]};
            C_BEQ:   return {6'h04, r[25:0]};
            C_LUI:   return {6'h0f, r[25:0]};
            C_J:     return {6'h02, r[25:0]};
            C_JAL:   return {6'h03, r[25:0]};
            default: return r[0] ? 32'h0 : {6'h08, r[25:0]};
        endcase
    endfunction

    // Runs one instruction; fs/ms are memory stall cycles in fetch/data access.
    task automatic run_instr(input int c, input int fs, input int ms,
                             input logic z);
        int st[$];
        logic rdy[$];
        int e_npc, e_rw, e_alu, e_eop, e_data, e_mw;
        int o_npc, o_rw, o_alu, o_ir, o_fetch, o_data, o_mw;
        bit is_mem, has_exec, wb_alu;

        is_mem   = (c == C_LW) || (c == C_SW);
        wb_alu   = (c == C_ADDU) || (c == C_SUBU) || (c == C_ORI) || (c == C_LUI);
        has_exec = wb_alu || is_mem || (c == C_BEQ);

        for (int i = 0; i < fs; i++) begin st.push_back(0); rdy.push_back(0); end
        st.push_back(0); rdy.push_back(1);
        st.push_back(1); rdy.push_back(1'($urandom));
        if (has_exec) begin st.push_back(2); rdy.push_back(1'($urandom)); end
        if (is_mem) begin
            for (int i = 0; i < ms; i++) begin st.push_back(3); rdy.push_back(0); end
            st.push_back(3); rdy.push_back(1);
        end
        if (wb_alu) begin st.push_back(4); rdy.push_back(1'($urandom)); end
        if (c == C_LW) begin st.push_back(5); rdy.push_back(1'($urandom)); end

        e_npc = 4;
        if (c == C_BEQ && z) e_npc = (e_npc << 3) | 5;
        if (c == C_J || c == C_JAL) e_npc = (e_npc << 3) | 6;
        if (c == C_JR) e_npc = (e_npc << 3) | 7;
        case (c)
            C_ADDU, C_SUBU: e_rw = 'h14;
            C_ORI, C_LUI:   e_rw = 'h10;
            C_LW:           e_rw = 'h11;
            C_JAL:          e_rw = 'h1a;
            default:        e_rw = 0;
        endcase
        case (c)
            C_ADDU:         e_alu = 0;
            C_SUBU, C_BEQ:  e_alu = 2;
            C_ORI, C_LUI:   e_alu = 5;
            C_LW, C_SW:     e_alu = 1;
            default:        e_alu = 7;
        endcase
        e_eop  = (c == C_ORI) ? 1 : (c == C_LUI) ? 2 : (c == C_BEQ) ? 3 : 0;
        e_data = is_mem ? ms + 1 : 0;
        e_mw   = (c == C_SW) ? ms + 1 : 0;

        o_npc = 0; o_rw = 0; o_alu = 7; o_ir = 0;
        o_fetch = 0; o_data = 0; o_mw = 0;

        for (int k = 0; k < st.size(); k++) begin
            @(negedge clk);
            if (k == 0) instr = enc(c);
            mem_ready = rdy[k];
            zero = z;
            #1;
`ifdef MC_INSTR_CNT_EN
            if (k == 0) check("instr_cnt", instr_cnt, exp_cnt);
`endif
            check($sformatf("state c%0d k%0d", c, k), state_o, st[k]);
            check($sformatf("EOp c%0d k%0d", c, k), EOp, e_eop);
            if (PCWr)  o_npc = (o_npc << 3) | 4 | NPCSel;
            if (RegWr) o_rw = (o_rw << 5) | 'h10 | (RegDst << 2) | WDSel;
            if (st[k] == 2) o_alu = {ALUOp, ALUSrc};
            o_ir    += IRWr;
            o_fetch += (mem_req && !mem_sel);
            o_data  += (mem_req && mem_sel);
            o_mw    += MemWr;
        end
        exp_cnt++;

        check($sformatf("pc_writes c%0d", c), o_npc, e_npc);
        check($sformatf("reg_writes c%0d", c), o_rw, e_rw);
        check($sformatf("alu_cfg c%0d", c), o_alu, e_alu);
        check($sformatf("irwr c%0d", c), o_ir, 1);
        check($sformatf("fetch_req c%0d", c), o_fetch, fs + 1);
        check($sformatf("data_req c%0d", c), o_data, e_data);
        check($sformatf("memwr c%0d", c), o_mw, e_mw);
    endtask

    initial begin
        reset = 1'b1;
        instr = 32'h3402FFFF;
        zero = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst state", state_o, 0);
        check("rst enables", {mem_req, PCWr, IRWr, RegWr, MemWr}, 0);
        check("rst selects", {mem_sel, NPCSel, EOp, ALUOp, ALUSrc, RegDst, WDSel}, 0);
`ifdef MC_INSTR_CNT_EN
        check("rst cnt", instr_cnt, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;

        for (int c = 0; c <= C_NOP; c++) run_instr(c, 0, 0, 1'b1);
        run_instr(C_BEQ, 0, 0, 1'b0);
        run_instr(C_LW, 0, 2, 1'b0);
        run_instr(C_SW, 1, 1, 1'b0);

        // Reset while a store is waiting in MEM.
        instr = enc(C_SW);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_ready = (k < 3);
        end
        #1;
        check("sw mem state", state_o, 3);
        check("sw memwr", MemWr, 1);
        reset = 1'b1;
        #1;
        check("rst comb memwr", MemWr, 0);
        check("rst comb req", mem_req, 0);
        @(posedge clk);
        #1;
        check("abort state", state_o, 0);
        check("abort memwr", MemWr, 0);
        check("abort req", mem_req, 0);
`ifdef MC_INSTR_CNT_EN
        check("abort cnt", instr_cnt, 0);
`endif
        exp_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;

        for (int n = 0; n < 3; n++) run_instr(C_ADDU, 0, 0, 1'b0);
        for (int n = 0; n < 80; n++) begin
            run_instr(int'($urandom_range(0, 10)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), 1'($urandom));
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("final state", state_o, 0);
`ifdef MC_INSTR_CNT_EN
        check("final cnt", instr_cnt, exp_cnt);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("cnt after reset", instr_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
